vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: system clocks per pixel; legal range 1..16.
REQ-002 SHALL have parameter H_VISIBLE, default 640: visible pixels per line.
REQ-003 SHALL have parameter V_VISIBLE, default 480: visible lines per frame.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port hPos  output  10  current horizontal pixel count, 0..799.
REQ-007 SHALL have port vPos  output  10  current line count, 0..524.
REQ-008 SHALL have port hsync  output  1  horizontal sync, active-low.
REQ-009 SHALL have port vsync  output  1  vertical sync, active-low.
REQ-010 SHALL have port visible  output  1  high when the current position is in the active area.
REQ-011 SHALL have port pix_tick  output  1  one-clk strobe marking the clock edge on which the position advances.
REQ-012 SHALL have port frame_start  output  1  one-clk pulse at the start of each frame.

Function
REQ-013 SHALL run an internal divider counting 0..CLK_DIV-1 and assert pix_tick while it equals CLK_DIV-1 (pix_tick constantly high when CLK_DIV=1).
REQ-014 SHALL advance hPos by 1 on each clk edge where pix_tick is high, and hold hPos and vPos otherwise.
REQ-015 SHALL use horizontal timing: total 800, visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 SHALL use vertical timing: total 525, visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 SHALL wrap hPos 799 -> 0 and, on that same edge, increment vPos.
REQ-018 SHALL wrap vPos 524 -> 0 only when hPos also wraps, so (799,524) -> (0,0) in one edge.
REQ-019 SHALL register hsync, vsync and visible so that they are cycle-aligned with hPos/vPos, with no combinational decode on the output path.
REQ-020 SHALL drive hsync low exactly while hPos is in 656..751, and vsync low exactly while vPos is in 490..491, regardless of hPos.
REQ-021 SHALL drive visible high exactly while hPos < H_VISIBLE and vPos < V_VISIBLE.
REQ-022 SHALL drive frame_start high for exactly one clk cycle: the first cycle in which the position is (0,0).
REQ-023 SHALL keep every output glitch-free and free of X after reset.

Reset
REQ-024 SHALL, while rst_n is low and independent of clk, force the following values: divider = 0, hPos = 799, vPos = 524, hsync = 1, vsync = 1, visible = 0, pix_tick = 0, frame_start = 0.
REQ-025 SHALL, after rst_n releases, advance to (0,0) on the first pix_tick and pulse frame_start, so that every frame starts cleanly.
REQ-026 SHALL return immediately to the REQ-024 state when reset is asserted mid-line or mid-frame, with no partial sync pulse held low.

Structure
REQ-027 SHALL take the H/V totals, porch and sync boundaries from the shared package vga_pkg, which SHALL also be used by the downstream colour stage.
REQ-028 SHALL place the divider in the sub-module pix_tick_gen (parameter CLK_DIV; ports clk, rst_n, pix_tick).
REQ-029 SHALL implement the counters and registered decode in vga_timing itself; the block SHALL need no other sub-modules.

Verification
REQ-030 SHALL cover reset release with CLK_DIV=2: the first pix_tick appears on the 2nd clk edge; the position goes to (0,0), frame_start is high for 1 clk and visible goes to 1.
REQ-031 SHALL cover one full line: hsync is low for exactly 96 pix_ticks, starting at hPos=656; visible falls at hPos=640; vPos increments at the 799 -> 0 wrap.
REQ-032 SHALL cover one full frame: there are 525 hPos wraps, vsync is low for 2 lines (490, 491), there is exactly 1 frame_start per 420000 pix_ticks, and 307200 cycles have visible high.
REQ-033 SHALL cover CLK_DIV=1: pix_tick is constantly high, the position advances every clk, and a frame takes 420000 clks.
REQ-034 SHALL cover reset asserted at (700,491) with hsync and vsync low: outputs go to (799,524) immediately with hsync=vsync=1, and a fresh frame_start follows the release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, used by the timing generator and
// the downstream colour stage.
package vga_pkg;
   localparam int POS_W      = 10;
   localparam int H_TOTAL    = 800;
   localparam int H_VIS      = 640;
   localparam int H_SYNC_BEG = 656;
   localparam int H_SYNC_END = 751;
   localparam int V_TOTAL    = 525;
   localparam int V_VIS      = 480;
   localparam int V_SYNC_BEG = 490;
   localparam int V_SYNC_END = 491;

   typedef logic [POS_W-1:0] pos_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic visible;
      logic frame_start;
   } vga_ctl_t;

   // Inclusive window test on a counter value.
   function automatic logic in_win(input pos_t p, input int lo, input int hi);
      return (int'(p) >= lo) && (int'(p) <= hi);
   endfunction
endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate strobe: divides clk by CLK_DIV and emits a registered one-clk tick.
module pix_tick_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic pix_tick
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] r_div;
   logic [DW-1:0] w_div_nxt;
   logic          r_tick;

   assign w_div_nxt = (r_div == LAST) ? '0 : r_div + 1'b1;

   // Tick is registered from the next divider value so it is high exactly
   // while the divider sits at CLK_DIV-1, and low throughout reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_div  <= w_div_nxt;
         r_tick <= (w_div_nxt == LAST);
      end
   end

   assign pix_tick = r_tick;
endmodule

// File: rtl/vga_timing.sv
// VGA raster counters with registered sync/visible/frame_start decode.
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int V_VISIBLE = 480
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] hPos,
   output logic [9:0] vPos,
   output logic       hsync,
   output logic       vsync,
   output logic       visible,
   output logic       pix_tick,
   output logic       frame_start
);
   logic     w_tick;
   pos_t     r_hPos, r_vPos;
   pos_t     w_h_nxt, w_v_nxt;
   vga_ctl_t r_ctl, w_ctl_nxt;

   pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .pix_tick (w_tick)
   );

   // Decode is computed on the next position so the registered flags line up
   // with the registered counters.
   always_comb begin
      w_h_nxt = r_hPos + 1'b1;
      w_v_nxt = r_vPos;
      if (r_hPos == pos_t'(H_TOTAL - 1)) begin
         w_h_nxt = '0;
         w_v_nxt = (r_vPos == pos_t'(V_TOTAL - 1)) ? '0 : r_vPos + 1'b1;
      end
      w_ctl_nxt.hsync       = !in_win(w_h_nxt, H_SYNC_BEG, H_SYNC_END);
      w_ctl_nxt.vsync       = !in_win(w_v_nxt, V_SYNC_BEG, V_SYNC_END);
      w_ctl_nxt.visible     = (int'(w_h_nxt) < H_VISIBLE) && (int'(w_v_nxt) < V_VISIBLE);
      w_ctl_nxt.frame_start = (w_h_nxt == '0) && (w_v_nxt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hPos <= pos_t'(H_TOTAL - 1);
         r_vPos <= pos_t'(V_TOTAL - 1);
         r_ctl  <= '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0, frame_start: 1'b0};
      end else if (w_tick) begin
         r_hPos <= w_h_nxt;
         r_vPos <= w_v_nxt;
         r_ctl  <= w_ctl_nxt;
      end else begin
         r_ctl.frame_start <= 1'b0;
      end
   end

   assign hPos        = r_hPos;
   assign vPos        = r_vPos;
   assign hsync       = r_ctl.hsync;
   assign vsync       = r_ctl.vsync;
   assign visible     = r_ctl.visible;
   assign frame_start = r_ctl.frame_start;
   assign pix_tick    = w_tick;
endmodule
